// File: rtl/tap_delay_pkg.sv
// Shared constants and elaboration helpers for the tap delay line.
// Contents:
//   WIDTH_DEF, DEPTH_DEF, NUM_TAPS_DEF - default parameter values
//   sel_width(depth)                   - tap select width, guarded for depth <= 1
//   cnt_width(depth)                   - fill counter width (counts 0..depth)
//   clamp_sel(sel, depth)              - maps out-of-range tap selects to the last stage
package tap_delay_pkg;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned NUM_TAPS_DEF = 2;

    // $clog2(1) is 0, which would give a zero-width select; keep at least one bit.
    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Only reachable for non-power-of-two depths, where the select can encode
    // indices beyond the last stage.
    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned depth);
        return (sel >= depth) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// Sample stream and tap bus of the tap delay line.
// Signals:
//   en, flush          - advance / synchronous clear (flush wins)
//   in_valid, in_data  - sample entering stage 0
//   tap_sel            - per-tap stage index
//   tap_data/tap_valid - per-tap read of the selected stage
//   fill_cnt, full     - enabled shifts since reset/flush, saturating at DEPTH
// Modports: master drives the stream and selects, slave is the delay line.
interface tap_delay_line_if
    import tap_delay_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned NUM_TAPS = NUM_TAPS_DEF
);
    localparam int unsigned SELW = sel_width(DEPTH);
    localparam int unsigned CNTW = cnt_width(DEPTH);

    logic                               en;
    logic                               flush;
    logic                               in_valid;
    logic [WIDTH-1:0]                   in_data;
    logic [NUM_TAPS-1:0][SELW-1:0]      tap_sel;
    logic [NUM_TAPS-1:0][WIDTH-1:0]     tap_data;
    logic [NUM_TAPS-1:0]                tap_valid;
    logic [CNTW-1:0]                    fill_cnt;
    logic                               full;

    modport master (
        output en, flush, in_valid, in_data, tap_sel,
        input  tap_data, tap_valid, fill_cnt, full
    );

    modport slave (
        input  en, flush, in_valid, in_data, tap_sel,
        output tap_data, tap_valid, fill_cnt, full
    );

endinterface

// File: rtl/delay_stage.sv
// One stage of the delay line: a WIDTH-bit data register and its valid bit.
// Ports:
//   clk, rstn            - clock, async active-low reset
//   en, flush            - load from input / clear (flush wins)
//   in_valid, in_data    - value loaded on an enabled edge
//   out_valid, out_data  - registered stage contents
module delay_stage
    import tap_delay_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // Data is captured regardless of in_valid; consumers qualify with the valid bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (flush) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (en) begin
            data_q <= in_data;
            vld_q  <= in_valid;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;

endmodule

// File: rtl/tap_delay_line.sv
// Multi-tap delay line: DEPTH stages with per-stage valid, NUM_TAPS runtime-selectable
// taps, stall (en), synchronous flush and a saturating fill counter.
// Ports:
//   clk, rstn - clock, async active-low reset
//   bus       - slave side of tap_delay_line_if (stream in, taps and fill status out)
// A tap with select s shows a sample s+1 enabled edges after it was accepted.
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned NUM_TAPS = NUM_TAPS_DEF
) (
    input logic             clk,
    input logic             rstn,
    tap_delay_line_if.slave bus
);

    localparam int unsigned SELW = sel_width(DEPTH);
    localparam int unsigned CNTW = cnt_width(DEPTH);

    if (DEPTH < 2) begin : g_depth_chk
        $fatal(1, "tap_delay_line: DEPTH must be >= 2");
    end
    if (NUM_TAPS < 1) begin : g_taps_chk
        $fatal(1, "tap_delay_line: NUM_TAPS must be >= 1");
    end

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             stage_vld  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;

        if (i == 0) begin : g_head
            assign d_in = bus.in_data;
            assign v_in = bus.in_valid;
        end else begin : g_body
            assign d_in = stage_data[i-1];
            assign v_in = stage_vld[i-1];
        end

        delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .en        (bus.en),
            .flush     (bus.flush),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (stage_vld[i]),
            .out_data  (stage_data[i])
        );
    end

    // Counts enabled shifts, not valid entries, so bubbles still advance it.
    logic [CNTW-1:0] fill_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_q <= '0;
        end else if (bus.flush) begin
            fill_q <= '0;
        end else if (bus.en && (fill_q != CNTW'(DEPTH))) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    assign bus.fill_cnt = fill_q;
    assign bus.full     = (fill_q == CNTW'(DEPTH));

    // Tap reads are pure muxes on registered state; only tap_sel is a comb input.
    logic [SELW-1:0] tap_idx [NUM_TAPS];

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap_idx
        assign tap_idx[k] = SELW'(clamp_sel(32'(bus.tap_sel[k]), DEPTH));
    end

    always_comb begin
        bus.tap_data  = '0;
        bus.tap_valid = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            bus.tap_data[k]  = stage_data[tap_idx[k]];
            bus.tap_valid[k] = stage_vld[tap_idx[k]];
        end
    end

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a history-queue model.
module tb_tap_delay_line;
    import tap_delay_pkg::*;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned NUM_TAPS = 2;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    tap_delay_line_if #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_TAPS (NUM_TAPS)
    ) bus ();

    tap_delay_line #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_TAPS (NUM_TAPS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted samples, newest first; entry s is what stage s holds.
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } samp_t;

    samp_t hist[$];
    int    shifts = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist.delete();
            shifts = 0;
        end else if (bus.flush) begin
            hist.delete();
            shifts = 0;
        end else if (bus.en) begin
            hist.push_front('{v: bus.in_valid, d: bus.in_data});
            if (hist.size() > DEPTH) void'(hist.pop_back());
            shifts++;
        end
    end

    function automatic samp_t m_tap(input int sel);
        int s;
        s = (sel >= int'(DEPTH)) ? int'(DEPTH) - 1 : sel;
        if (s < hist.size()) return hist[s];
        return '0;
    endfunction

    function automatic int m_fill();
        return (shifts > int'(DEPTH)) ? int'(DEPTH) : shifts;
    endfunction

    // Continuous comparison, after each edge has settled and before inputs change.
    always @(posedge clk) begin
        samp_t e;
        #3;
        for (int k = 0; k < int'(NUM_TAPS); k++) begin
            e = m_tap(int'(bus.tap_sel[k]));
            check($sformatf("model tap_data[%0d]", k), 32'(bus.tap_data[k]), 32'(e.d));
            check($sformatf("model tap_valid[%0d]", k), 32'(bus.tap_valid[k]), 32'(e.v));
        end
        check("model fill_cnt", 32'(bus.fill_cnt), 32'(m_fill()));
        check("model full", 32'(bus.full), 32'(m_fill() == int'(DEPTH)));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [4:0] pat [8];

    initial begin
        rstn         = 1'b0;
        bus.en       = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        bus.tap_sel  = {3'd1, 3'd0};

        // Reset held with a live stream at the inputs.
        repeat (2) @(negedge clk);
        check("rst tap_data", 32'(bus.tap_data), 32'h0);
        check("rst tap_valid", 32'(bus.tap_valid), 32'h0);
        check("rst fill_cnt", 32'(bus.fill_cnt), 32'h0);
        check("rst full", 32'(bus.full), 32'h0);
        rstn = 1'b1;
        step();
        check("first edge tap0", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h1F);
        check("first edge tap1", 32'({bus.tap_valid[1], bus.tap_data[1]}), 32'h00);
        check("first edge fill", 32'(bus.fill_cnt), 32'd1);

        // Legacy taps 3 and 7 with a counting stream, stalled after the 5th shift.
        bus.flush = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.tap_sel  = {3'd7, 3'd3};
        bus.in_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            bus.en      = 1'b1;
            bus.in_data = 4'(c);
            step();
            if (c == 3) check("legacy tap0 not yet", 32'(bus.tap_valid[0]), 32'h0);
            if (c == 4) check("legacy tap0 first", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h11);
            if (c == 6) check("resume tap0", 32'(bus.tap_data[0]), 32'h3);
            if (c == 7) check("legacy not full", 32'(bus.full), 32'h0);
            if (c == 8) begin
                check("legacy tap1 first", 32'({bus.tap_valid[1], bus.tap_data[1]}), 32'h11);
                check("legacy full", 32'(bus.full), 32'h1);
            end
            if (c == 5) begin
                bus.en      = 1'b0;
                bus.in_data = 4'hE;
                for (int j = 0; j < 3; j++) begin
                    step();
                    check("stall tap0 hold", 32'(bus.tap_data[0]), 32'h2);
                    check("stall fill hold", 32'(bus.fill_cnt), 32'd5);
                end
            end
        end

        // Flush together with en: the incoming 0xA is dropped.
        bus.flush    = 1'b1;
        bus.en       = 1'b1;
        bus.in_data  = 4'hA;
        bus.in_valid = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.en    = 1'b0;
        check("flush tap_valid", 32'(bus.tap_valid), 32'h0);
        check("flush tap_data", 32'(bus.tap_data), 32'h0);
        check("flush fill", 32'(bus.fill_cnt), 32'h0);
        for (int s = 0; s < int'(DEPTH); s++) begin
            bus.tap_sel = {3'(s), 3'(s)};
            #1;
            check("flush sweep tap_data", 32'(bus.tap_data), 32'h0);
        end

        // Bubbles: valid pattern 1,0,1 carrying 5,6,7, then empty filler.
        pat = '{5'h15, 5'h06, 5'h17, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        bus.tap_sel = {3'd4, 3'd2};
        bus.en      = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            {bus.in_valid, bus.in_data} = pat[n-1];
            step();
            if (n == 3) check("bubble tap0 n3", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h15);
            if (n == 4) check("bubble tap0 n4", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h06);
            if (n == 5) begin
                check("bubble tap0 n5", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h17);
                check("bubble tap1 n5", 32'({bus.tap_valid[1], bus.tap_data[1]}), 32'h15);
            end
            if (n == 6) check("bubble tap1 n6", 32'({bus.tap_valid[1], bus.tap_data[1]}), 32'h06);
            if (n == 7) check("bubble tap1 n7", 32'({bus.tap_valid[1], bus.tap_data[1]}), 32'h17);
        end
        bus.en         = 1'b0;
        bus.tap_sel[0] = 3'd5;
        #1;
        check("retarget tap0", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h17);
        check("retarget full", 32'(bus.full), 32'h1);

        // Asynchronous reset pulse between edges.
        #1 rstn = 1'b0;
        #1;
        check("async rst tap_data", 32'(bus.tap_data), 32'h0);
        check("async rst tap_valid", 32'(bus.tap_valid), 32'h0);
        check("async rst fill", 32'(bus.fill_cnt), 32'h0);
        check("async rst full", 32'(bus.full), 32'h0);
        #1 rstn = 1'b1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h3;
        bus.tap_sel  = {3'd1, 3'd0};
        step();
        check("post rst tap0", 32'({bus.tap_valid[0], bus.tap_data[0]}), 32'h13);
        check("post rst tap1", 32'(bus.tap_valid[1]), 32'h0);

        // Randomized traffic; the continuous comparison does the checking.
        for (int i = 0; i < 400; i++) begin
            bus.en       = ($urandom_range(0, 9) < 7);
            bus.flush    = ($urandom_range(0, 24) == 0);
            bus.in_valid = 1'($urandom);
            bus.in_data  = 4'($urandom);
            bus.tap_sel  = 6'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
# tap_delay_line

Parametrised multi-tap delay line for the controller datapath. It delays a WIDTH-bit sample stream by up to DEPTH enabled cycles and exposes NUM_TAPS independently and runtime-selectable taps, each with its own valid flag. Over the fixed 4-bit, two-tap shifter it adds stall (enable), synchronous flush, per-stage valid tracking and a fill counter. It sits between the input sequencer and the PE-array feeders, where skewed copies of one stream are needed.

## Interface
- WIDTH, 4, sample width in bits
- DEPTH, 8, number of stages; must be ≥ 2
- NUM_TAPS, 2, number of output taps; must be ≥ 1
- SELW, $clog2(DEPTH), tap select width (derived, not overridden)
- CNTW, $clog2(DEPTH+1), fill counter width (derived)

- clk  input  1  clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- en  input  1  advance the line by one stage this cycle
- flush  input  1  synchronous clear of all stages; priority over en
- in_valid  input  1  qualifies in_data
- in_data  input  WIDTH  sample entering stage 0
- tap_sel  input  NUM_TAPS×SELW  per-tap stage index; delay = tap_sel+1 enabled cycles
- tap_data  output  NUM_TAPS×WIDTH  data of selected stage, per tap
- tap_valid  output  NUM_TAPS  valid bit of selected stage, per tap
- fill_cnt  output  CNTW  enabled shifts since reset/flush, saturates at DEPTH
- full  output  1  fill_cnt == DEPTH

## Operation
- Storage: data[0..DEPTH-1] (WIDTH each) and vld[0..DEPTH-1].
- Reset (rstn low, async): all data, vld and fill_cnt = 0. So tap_data = 0, tap_valid = 0, fill_cnt = 0, full = 0.
- Per edge, in priority order:
  - flush=1: all data and vld clear to 0, and fill_cnt = 0. en and in_* are ignored that cycle.
  - en=1: data[i] <= data[i-1] and vld[i] <= vld[i-1] for i ≥ 1. data[0] <= in_data and vld[0] <= in_valid. fill_cnt <= min(fill_cnt+1, DEPTH).
  - en=0: all state holds. Stall does not lose or duplicate samples.
- in_data is stored even when in_valid=0. Consumers qualify data with tap_valid.
- Taps are combinational reads of registers: tap_data[k] = data[tap_sel[k]] and tap_valid[k] = vld[tap_sel[k]].
  - tap_sel[k] ≥ DEPTH (only possible for non-power-of-two DEPTH) clamps to DEPTH-1.
- Several taps may select the same stage. Each gets an identical copy.
- A tap_sel change takes effect in the same cycle. No re-alignment and no flush is implied.
- fill_cnt counts enabled shifts, not valid entries. It increments on en=1 whether in_valid is 0 or 1.

## Timing
- Latency: a sample accepted at enabled edge E is visible on a tap with tap_sel=s right after the s-th enabled edge following E, i.e. after s+1 enabled edges in total.
- With en held at 1: tap_sel=3 → 4 cycles and tap_sel=7 → 8 cycles. This matches the legacy delay_4/delay_8 taps.
- Outputs change only after a clk edge or a tap_sel change. There is no other comb path from inputs to outputs; in_data, in_valid, en and flush never reach tap_* combinationally.
- Simultaneous flush and en: flush wins. The incoming sample is dropped.
- Reset asserted mid-stream clears immediately, with no clock required. The first enabled edge after release loads stage 0 only.
- full asserts on the edge that makes fill_cnt = DEPTH and stays asserted until flush or reset.

## Structure
- Package tap_delay_pkg:
  - functions for the SELW/CNTW widths with DEPTH=1 guard
  - tap clamp function
  - default parameter constants WIDTH_DEF, DEPTH_DEF and NUM_TAPS_DEF
- Sub-module delay_stage: one WIDTH-bit data register plus one valid bit, with async reset, en and flush. It is instantiated DEPTH times in a generate loop.
- The top module holds the fill counter and the NUM_TAPS read muxes.
- Elaboration-time assertions check DEPTH ≥ 2 and NUM_TAPS ≥ 1.

## Test plan
- Reset: drive in_data=0xF, in_valid=1 and en=1 while rstn=0. Required: tap_data=0, tap_valid=0, fill_cnt=0, full=0. After release, the first edge shows 0xF on tap_sel=0 only.
- Legacy equivalence: WIDTH=4, DEPTH=8, taps {3,7}, en=1, in_valid=1, in_data = 1,2,3,… on successive cycles. Required: value 1 appears on tap0 4 cycles after entry and on tap1 8 cycles after entry. full rises on the 8th edge.
- Stall: drop en for 3 cycles mid-stream. Required: both taps hold their values. The stream then resumes with no gap or duplicate, and fill_cnt freezes during the stall.
- Flush versus en: assert flush and en together while in_data=0xA. Required: next cycle all tap_valid=0, tap_data=0 and fill_cnt=0. 0xA never appears on any tap.
- Bubbles and tap retarget: send the valid pattern 1,0,1 with values 5,6,7. Required: tap_valid follows 1,0,1 at each tap's delay. Switching tap_sel from 2 to 5 shows data[5] in the same cycle.
- Async reset mid-operation: pulse rstn low between edges while full. Required: all outputs are 0 immediately, before the next clk edge.
